uart_tx_fsm: RTL and testbench

UART_TX_FSM -- requirements
Module: uart_tx_fsm

---
 rtl/uart_tx_pkg.sv | 20 ++
 rtl/uart_tx_fsm.sv | 105 ++++++++++
 tb/tb_uart_tx_fsm.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// UART transmit control: shared state type and TX line select codes.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_STOP   = 2'b01;
  localparam logic [1:0] SEL_DATA   = 2'b10;
  localparam logic [1:0] SEL_PARITY = 2'b11;

endpackage

// File: rtl/uart_tx_fsm.sv
// UART transmit frame sequencer (Moore FSM).
// Optional parity bit enabled by the UART_TX_PARITY_EN macro.
module uart_tx_fsm
  import uart_tx_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       PAR_EN,
  input  logic       DATA_valid,
  input  logic       SER_done,
  output logic       SER_EN,
  output logic [1:0] MUX_sel,
  output logic       busy
);

  state_t r_state;
  state_t w_state_nxt;

`ifdef UART_TX_PARITY_EN
  logic r_par_en;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_par_en <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Sample parity mode once per frame, on entry to START
      if (w_state_nxt == ST_START)
        r_par_en <= PAR_EN;
    end
  end
`else
  logic w_unused_par_en;
  assign w_unused_par_en = PAR_EN;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end
`endif

  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE:
        w_state_nxt = DATA_valid ? ST_START : ST_IDLE;
      ST_START:
        w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (!SER_done)
          w_state_nxt = ST_DATA;
`ifdef UART_TX_PARITY_EN
        else if (r_par_en)
          w_state_nxt = ST_PARITY;
`endif
        else
          w_state_nxt = ST_STOP;
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY:
        w_state_nxt = ST_STOP;
`endif
      ST_STOP:
        w_state_nxt = DATA_valid ? ST_START : ST_IDLE;
      default:
        w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    SER_EN  = 1'b0;
    MUX_sel = SEL_STOP;
    busy    = 1'b0;
    case (r_state)
      ST_START: begin
        MUX_sel = SEL_START;
        busy    = 1'b1;
      end
      ST_DATA: begin
        SER_EN  = 1'b1;
        MUX_sel = SEL_DATA;
        busy    = 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        MUX_sel = SEL_PARITY;
        busy    = 1'b1;
      end
`endif
      ST_STOP: begin
        MUX_sel = SEL_STOP;
        busy    = 1'b1;
      end
      default: begin
        SER_EN  = 1'b0;
        MUX_sel = SEL_STOP;
        busy    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Randomized frame-plan bench for uart_tx_fsm.
// Expected line activity is built from frame descriptions, not state.
module tb_uart_tx_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       DATA_valid = 1'b0;
  logic       SER_done = 1'b0;
  logic       SER_EN;
  logic [1:0] MUX_sel;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  // expected {SER_EN, MUX_sel, busy} per cycle, plus stimulus per cycle
  logic [3:0] q_exp[$];
  logic       q_dv[$];
  logic       q_sd[$];
  logic       q_pe[$];
  int         n_busy;

  uart_tx_fsm dut (
    .CLK       (CLK),
    .RST       (RST),
    .PAR_EN    (PAR_EN),
    .DATA_valid(DATA_valid),
    .SER_done  (SER_done),
    .SER_EN    (SER_EN),
    .MUX_sel   (MUX_sel),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {SER_EN, MUX_sel, busy};
  endfunction

  // line symbol -> expected {SER_EN, MUX_sel, busy}
  task automatic push(input logic [1:0] sel, input logic bsy,
                      input logic dv, input logic sd);
    q_exp.push_back({sel == 2'b10, sel, bsy});
    q_dv.push_back(dv);
    q_sd.push_back(sd);
    q_pe.push_back(1'($urandom));
  endtask

  // one frame: gap idle cycles, start, n data bits, parity?, stop
  task automatic add_frame(input int gap, input int n, input logic p);
    logic p_eff;
    int   k;
`ifdef UART_TX_PARITY_EN
    p_eff = p;
`else
    p_eff = 1'b0;
`endif
    for (int i = 0; i < gap; i++)
      push(2'b01, 1'b0, 1'b0, 1'($urandom));
    k = q_dv.size() - 1;
    q_dv[k] = 1'b1;
    q_pe[k] = p;
    push(2'b00, 1'b1, 1'($urandom), 1'($urandom));
    for (int i = 0; i < n; i++)
      push(2'b10, 1'b1, 1'($urandom), i == n - 1);
    if (p_eff)
      push(2'b11, 1'b1, 1'($urandom), 1'($urandom));
    push(2'b01, 1'b1, 1'b0, 1'($urandom));
  endtask

  initial begin
    // reset held while DATA_valid is high
    DATA_valid = 1'b1;
    #1;
    chk("rst_async", 8'(outs()), 8'b0010);
    repeat (2) begin
      @(negedge CLK);
      chk("rst_hold", 8'(outs()), 8'b0010);
    end

    // plan: idle, directed frames, then random frames
    push(2'b01, 1'b0, 1'b0, 1'b0);
    add_frame(1, 4, 1'b1);
    add_frame(1, 4, 1'b0);
    add_frame(0, 1, 1'b1);
    add_frame(0, 3, 1'b0);
    for (int f = 0; f < 60; f++)
      add_frame($urandom_range(0, 3), $urandom_range(1, 9),
                1'($urandom));
    push(2'b01, 1'b0, 1'b0, 1'b0);
    push(2'b01, 1'b0, 1'b0, 1'b0);

    RST = 1'b0;
    DATA_valid = 1'b0;
    n_busy = 0;
    for (int t = 0; t < q_exp.size(); t++) begin
      chk($sformatf("cyc%0d", t), 8'(outs()), 8'(q_exp[t]));
      DATA_valid = q_dv[t];
      SER_done   = q_sd[t];
      PAR_EN     = q_pe[t];
      @(negedge CLK);
    end

    // directed frame busy-length check
    PAR_EN = 1'b1;
    DATA_valid = 1'b1;
    @(negedge CLK);
    DATA_valid = 1'b0;
    SER_done = 1'b0;
    n_busy = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) n_busy++;
      SER_done = (i == 4);
      @(negedge CLK);
    end
    SER_done = 1'b0;
`ifdef UART_TX_PARITY_EN
    chk("busy_len", 8'(n_busy), 8'd7);
`else
    chk("busy_len", 8'(n_busy), 8'd6);
`endif

    // abort in DATA
    DATA_valid = 1'b1;
    @(negedge CLK);
    DATA_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("pre_abort", 8'(outs()), 8'b1101);
    #2 RST = 1'b1;
    #1;
    chk("abort", 8'(outs()), 8'b0010);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_abort", 8'(outs()), 8'b0010);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
